// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared state, ALU field constants and idle instruction
package alu_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        CAPTURE = 3'd2,
        WB_LO   = 3'd3,
        WB_HI   = 3'd4
    } state_t;

    localparam logic [2:0] GRP_LOGIC = 3'd0;
    localparam logic [2:0] GRP_ARITH = 3'd1;
    localparam logic [2:0] GRP_SHIFT = 3'd2;

    localparam logic [2:0] OP_DIV = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;

    localparam logic [7:0] NOP_INSTR = 8'h38;

    function automatic logic updates_carry(input logic [7:0] instr);
        return instr[5:3] == GRP_ARITH && (instr[2:0] == OP_SUB || instr[2:0] == OP_ADD);
    endfunction

endpackage

// File: rtl/alu_sequencer_settle_counter.sv
// alu_settle_counter: 4-bit load/decrement counter with a zero flag
module alu_settle_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt;

    // load has priority over decrement
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= 4'd0;
        else if (load) cnt <= load_val;
        else if (dec) cnt <= cnt - 4'd1;
    end

    assign zero = cnt == 4'd0;

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one ALU request, waits for settle, captures and writes back one or two beats
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int REG_ADDR_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [7:0]            req_instr,
    input  logic [7:0]            req_a,
    input  logic [7:0]            req_b,
    input  logic [REG_ADDR_W-1:0] req_dst,
    output logic [7:0]            alu_instr,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    input  logic [7:0]            alu_c,
    input  logic [7:0]            alu_d,
    input  logic                  alu_d_out_en,
    input  logic                  alu_cf,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [7:0]            wb_data,
    output logic                  flag_cf,
    output logic                  busy
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t                state, state_n;
    logic                  rdy_q;
    logic                  accept;
    logic                  cnt_zero;
    logic [REG_ADDR_W-1:0] dst_q;
    logic [7:0]            d_q;
    logic                  hi_q;

    assign accept    = rdy_q && req_valid;
    assign req_ready = rdy_q;
    assign busy      = state != IDLE;

    alu_settle_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .dec      (state == SETTLE && !cnt_zero),
        .load_val (SETTLE_LOAD),
        .zero     (cnt_zero)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_n;
    end

    // next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? SETTLE : IDLE;
            SETTLE:  state_n = cnt_zero ? CAPTURE : SETTLE;
            CAPTURE: state_n = WB_LO;
            WB_LO:   state_n = wb_ready ? (hi_q ? WB_HI : IDLE) : WB_LO;
            WB_HI:   state_n = wb_ready ? IDLE : WB_HI;
            default: state_n = IDLE;
        endcase
    end

    // issue, capture and write-back registers; ready only after a full idle cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q     <= 1'b0;
            alu_instr <= NOP_INSTR;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            dst_q     <= '0;
            d_q       <= 8'h00;
            hi_q      <= 1'b0;
            flag_cf   <= 1'b0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= 8'h00;
        end else begin
            rdy_q <= state == IDLE && state_n == IDLE;
            if (accept) begin
                alu_instr <= req_instr;
                alu_a     <= req_a;
                alu_b     <= req_b;
                dst_q     <= req_dst;
            end
            if (state == CAPTURE) begin
                alu_instr <= NOP_INSTR;
                d_q       <= alu_d;
                hi_q      <= alu_d_out_en;
                flag_cf   <= updates_carry(alu_instr) ? alu_cf : flag_cf;
                wb_valid  <= 1'b1;
                wb_addr   <= dst_q;
                wb_data   <= alu_c;
            end
            if (state == WB_LO && wb_ready) begin
                wb_valid <= hi_q;
                wb_addr  <= dst_q + 1'b1;
                wb_data  <= d_q;
            end
            if (state == WB_HI && wb_ready) wb_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Issue and capture sequencer sitting on the driving side of the 8-bit ECP8 ALU. It accepts one ALU request at a time over a valid/ready handshake and registers the instruction byte and the A/B operands onto the ALU inputs. After a settle window it captures the combinational C/D/CF results. It then writes them back to the 8-bit register file as one beat, or two beats when the ALU asserts D_OUT_EN (MUL/DIV high byte / remainder).

Parameters:
SETTLE_CYCLES, 1, cycles ALU inputs are held before capture; legal range 1..15.
REG_ADDR_W, 4, register-file address width.
NOP_INSTR, 8'h38, instruction driven while idle; group field 7 enables no ALU group, so C=0, D_OUT_EN=0, CF=0.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_instr  in  8  ALU instruction: [2:0] op, [5:3] group (0 logic, 1 arith, 2 shift/rotate/neg), [7:6] ignored
req_a  in  8  operand A
req_b  in  8  operand B
req_dst  in  REG_ADDR_W  destination register for the low byte
alu_instr  out  8  registered instruction to ALU
alu_a  out  8  registered A to ALU
alu_b  out  8  registered B to ALU
alu_c  in  8  ALU C result
alu_d  in  8  ALU D result (high byte / remainder)
alu_d_out_en  in  1  D valid
alu_cf  in  1  ALU carry
wb_valid  out  1  write-back beat valid
wb_ready  in  1  register file accepts the beat
wb_addr  out  REG_ADDR_W  write-back address
wb_data  out  8  write-back data
flag_cf  out  1  registered carry flag
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, alu_instr=NOP_INSTR, alu_a=alu_b=0, wb_valid=0, wb_addr=0, wb_data=0, flag_cf=0, busy=0. req_ready=0 while rst=0 and 1 from the first edge after release.
- FSM states: IDLE, SETTLE, CAPTURE, WB_LO, WB_HI.
- IDLE: req_ready=1. When req_valid&req_ready, register req_instr/a/b onto alu_*, latch dst, load the settle counter with SETTLE_CYCLES-1, and go to SETTLE.
- SETTLE: ALU inputs held stable. Decrement the counter and go to CAPTURE when it reaches 0. Request-to-capture latency is SETTLE_CYCLES+1 edges.
- CAPTURE (1 cycle): latch c_q=alu_c, d_q=alu_d, hi_q=alu_d_out_en. Update flag_cf<=alu_cf only when group=1 and op is 3 (SUB) or 4 (ADD); otherwise flag_cf holds. Drive alu_instr<=NOP_INSTR. Go to WB_LO.
- WB_LO: wb_valid=1, wb_addr=dst, wb_data=c_q. On wb_ready go to WB_HI if hi_q, else to IDLE.
- WB_HI: wb_valid=1, wb_addr=dst+1 (mod 2^REG_ADDR_W, so 15 wraps to 0), wb_data=d_q. On wb_ready go to IDLE.
- wb_valid, wb_addr and wb_data are registered. They hold stable while wb_ready=0, with no timeout.
- req_ready=0 in every state except IDLE, so back-to-back requests cost at least SETTLE_CYCLES+3 cycles.
- Bits [7:6] of the instruction pass through unchanged to alu_instr.
- Reset mid-operation (any state) aborts everything. No partial write-back beat may be presented after reset.

Decomposition:
- Shared package: the state enum, the group constants (GRP_LOGIC=0, GRP_ARITH=1, GRP_SHIFT=2), the op constants (OP_SUB=3, OP_ADD=4, OP_MUL=2, OP_DIV=1), and NOP_INSTR.
- One natural sub-module: alu_settle_counter, a 4-bit load/decrement counter with a zero flag.

Test Plan:
- ADD carry, SETTLE_CYCLES=1: instr=8'h0C, A=8'hF0, B=8'h20, dst=3 -> one beat, wb_addr=3, wb_data=8'h10; flag_cf=1 from CAPTURE onward; req_ready low for exactly 4 cycles, including the beat accepted in its first cycle.
- MUL two-beat: instr=8'h0A, A=8'h10, B=8'h20, dst=15 -> beat 1 addr 15 data 8'h00, beat 2 addr 0 data 8'h02 (wrap); flag_cf unchanged.
- Logic op leaves the flag: set flag_cf=1 via the ADD case, then instr=8'h03 (AND), A=8'hF0, B=8'h3C -> wb_data=8'h30, flag_cf still 1.
- Write-back stall: wb_ready=0 for 5 cycles in WB_LO -> wb_valid, wb_addr and wb_data stable throughout; req_ready=0; completes on the first cycle wb_ready=1.
- Reset mid-MUL: rst=0 during WB_HI -> all outputs take their reset values asynchronously, alu_instr=8'h38, no further wb_valid after release, a new request accepted normally.
- SETTLE_CYCLES=3: capture occurs on the 4th edge after the handshake; alu_a/alu_b/alu_instr unchanged during SETTLE even if req_* toggles.
